mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Initiator side of the data-RAM interface: accepts one load/store request at a time from the CPU pipeline and drives the synchronous-read data RAM.
- RAM contract: word-wide write on wr_en at the clock edge; address registered at the edge, read data valid the following cycle.
- Handles byte/half/word sizing, little-endian lane selection, sign extension and read-modify-write for sub-word stores.
- Sits between the execute/memory stage and the data RAM.

Parameters:
- ADDR_W, 20: byte-address width, equal to RAM_ADDRESS_BITWIDTH; RAM word index is address[ADDR_W-1:2].

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  1  request offered
- req_ready  out  1  unit idle, request accepted when req_valid & req_ready
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word (3 treated as misaligned)
- req_signed  in  1  sign-extend load result
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle completion pulse
- resp_err  out  1  misaligned/illegal-size flag, qualified by resp_valid
- resp_rdata  out  32  load result, qualified by resp_valid
- ram_wr_en  out  1  RAM write enable
- ram_address  out  ADDR_W  RAM byte address, low 2 bits forced to 0
- ram_write_data  out  32  RAM write word
- ram_data  in  32  RAM read data

Behaviour:
- Reset: state IDLE; req_ready=1; resp_valid=0, resp_err=0, resp_rdata=0, ram_wr_en=0, ram_address=0, ram_write_data=0. Asserting rst mid-operation drops the request: no write reaches RAM after the rst edge and no response is produced.
- All ram_* and resp_* outputs are registered. req_ready = (state==IDLE), combinational from state.
- Alignment check at accept: half requires addr[0]=0; word requires addr[1:0]=0; size 3 is always illegal.
  - Illegal request: no RAM access; next cycle resp_valid=1, resp_err=1, resp_rdata=0; state stays IDLE.
- Byte lanes are little-endian: offset 0 = bits 7:0, offset 3 = bits 31:24.
- States: IDLE, LD_ADDR, LD_DATA, ST_WRITE, RMW_ADDR, RMW_DATA, RMW_WRITE.
- Load (accept edge E0):
  - E0: ram_address <= aligned addr → LD_ADDR.
  - E1: RAM latches address → LD_DATA.
  - E2: resp_rdata <= extract(ram_data, size, offset, signed); resp_valid <= 1 → IDLE.
  - Accept to resp_valid: 3 cycles. Unsigned loads zero-extend.
- Word store:
  - E0: ram_address, ram_write_data <= wdata, ram_wr_en <= 1 → ST_WRITE.
  - E1: RAM writes; ram_wr_en <= 0, resp_valid <= 1, resp_rdata <= 0 → IDLE.
- Sub-word store (read-modify-write):
  - E0: ram_address set, ram_wr_en stays 0 → RMW_ADDR.
  - E1: → RMW_DATA.
  - E2: ram_write_data <= merge(ram_data, wdata lanes); ram_wr_en <= 1 → RMW_WRITE.
  - E3: write occurs; ram_wr_en <= 0, resp_valid <= 1 → IDLE.
  - Unselected bytes preserve the RAM contents read at E2.
- ram_wr_en is high for exactly one cycle per store and never high for loads or illegal requests.
- resp_valid is a single-cycle pulse. It coincides with the first IDLE cycle, so a new request may be accepted in the same cycle resp_valid is high: back-to-back operation with no bubble beyond the latency above.
- Request inputs are sampled only at the accept edge and may change afterwards.
- ram_address holds its last value while idle.

Decomposition:
- Package mem_access_pkg:
  - size enum: SIZE_B=0, SIZE_H=1, SIZE_W=2.
  - state enum.
  - Function is_aligned(size, addr[1:0]).
- Sub-module mem_lane_align (combinational):
  - extract: word, size, offset, signed → 32-bit result.
  - merge: old word, wdata, size, offset → 32-bit word.
  - Instantiated once for each function.

Test Plan:
- Word store then load: store 0xDEADBEEF @0x10, then word load @0x10 → ram_wr_en pulse 1 cycle with ram_address=0x10; load resp_rdata=0xDEADBEEF, resp_err=0, resp_valid 3 cycles after accept.
- Byte RMW: RAM word @0x20 = 0x11223344; store byte 0xAA @0x22 → RAM word 0x11AA3344; store ack 4 cycles after accept; lanes 0, 1, 3 untouched.
- Signed/unsigned extract: word @0x30 = 0x80FF7F01 → signed byte @0x32 = 0xFFFFFFFF; unsigned byte @0x32 = 0x000000FF; signed half @0x32 = 0xFFFF80FF; signed byte @0x31 = 0x0000007F.
- Misaligned: half load @0x31, then word store @0x22 → each gives resp_valid 1 cycle after accept with resp_err=1, resp_rdata=0; ram_wr_en never asserted; RAM word unchanged.
- Back-to-back: issue a new request in the cycle resp_valid is high → accepted that cycle; two word loads complete 3 cycles apart.
- Reset mid-RMW: assert rst while in RMW_DATA → ram_wr_en=0 immediately, no resp_valid, RAM word unchanged, req_ready=1 after release.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared types for the data-RAM access unit.
//   size_e   : access size encoding on req_size (3 is never legal)
//   state_e  : control FSM states
//   req_t    : request fields captured at the accept edge
//   is_aligned(): legality/alignment check done at accept
package mem_access_pkg;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2
    } size_e;

    typedef enum logic [2:0] {
        IDLE,
        LD_ADDR,
        LD_DATA,
        ST_WRITE,
        RMW_ADDR,
        RMW_DATA,
        RMW_WRITE
    } state_e;

    typedef struct packed {
        logic [1:0]  size;
        logic [1:0]  off;
        logic        sgn;
        logic [31:0] wdata;
    } req_t;

    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] off);
        logic ok;
        case (size)
            SIZE_B:  ok = 1'b1;
            SIZE_H:  ok = ~off[0];
            SIZE_W:  ok = (off == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian byte-lane steering for the access unit (combinational).
//   MERGE=0 : result_o = extract(word_i, size_i, offset_i, signed_i)
//             sub-word field at offset, sign- or zero-extended to 32 bits.
//   MERGE=1 : result_o = merge(word_i, wdata_i, size_i, offset_i)
//             word_i with the selected lanes replaced by right-aligned wdata_i.
// Ports: word_i (RAM word), wdata_i (store data), size_i, offset_i (addr[1:0]),
//        signed_i, result_o.
import mem_access_pkg::*;

module mem_lane_align #(
    parameter bit MERGE = 1'b0
) (
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  size_i,
    input  logic [1:0]  offset_i,
    input  logic        signed_i,
    output logic [31:0] result_o
);

    logic [4:0]  shamt;
    logic [31:0] shifted;
    logic [31:0] extracted;
    logic [31:0] mask;
    logic [31:0] merged;

    assign shamt   = {offset_i, 3'b000};
    assign shifted = word_i >> shamt;

    always_comb begin
        extracted = 32'h0;
        case (size_i)
            SIZE_B:  extracted = {{24{signed_i & shifted[7]}},  shifted[7:0]};
            SIZE_H:  extracted = {{16{signed_i & shifted[15]}}, shifted[15:0]};
            SIZE_W:  extracted = word_i;
            default: extracted = 32'h0;
        endcase
    end

    always_comb begin
        mask = 32'h0;
        case (size_i)
            SIZE_B:  mask = 32'h0000_00FF << shamt;
            SIZE_H:  mask = 32'h0000_FFFF << shamt;
            SIZE_W:  mask = 32'hFFFF_FFFF;
            default: mask = 32'h0;
        endcase
    end

    // Upper bits of wdata beyond the access size are masked off.
    assign merged   = (word_i & ~mask) | ((wdata_i << shamt) & mask);
    assign result_o = MERGE ? merged : extracted;

endmodule

// File: rtl/mem_access_unit.sv
// Data-RAM initiator: one load/store at a time, sized little-endian accesses,
// sign extension on loads, read-modify-write for byte/half stores.
// RAM is synchronous-read: address sampled at an edge, data valid next cycle.
// Ports:
//   clk, rst                  clock, async active-high reset
//   req_valid/req_ready       request handshake (ready = idle)
//   req_we/size/signed/addr/wdata  request fields, sampled at accept only
//   resp_valid/err/rdata      registered one-cycle completion
//   ram_wr_en/address/write_data  registered RAM drive; ram_data read return
import mem_access_pkg::*;

module mem_access_unit #(
    parameter int ADDR_W = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [31:0]       resp_rdata,
    output logic              ram_wr_en,
    output logic [ADDR_W-1:0] ram_address,
    output logic [31:0]       ram_write_data,
    input  logic [31:0]       ram_data
);

    state_e            state_q, state_d;
    req_t              req_q, req_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [31:0]       ram_wdata_q, ram_wdata_d;
    logic              ram_wr_en_q, ram_wr_en_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_err_q, resp_err_d;
    logic [31:0]       resp_rdata_q, resp_rdata_d;

    logic [31:0]       ld_word;
    logic [31:0]       rmw_word;

    mem_lane_align #(.MERGE(1'b0)) u_extract (
        .word_i   (ram_data),
        .wdata_i  (req_q.wdata),
        .size_i   (req_q.size),
        .offset_i (req_q.off),
        .signed_i (req_q.sgn),
        .result_o (ld_word)
    );

    mem_lane_align #(.MERGE(1'b1)) u_merge (
        .word_i   (ram_data),
        .wdata_i  (req_q.wdata),
        .size_i   (req_q.size),
        .offset_i (req_q.off),
        .signed_i (req_q.sgn),
        .result_o (rmw_word)
    );

    assign req_ready = (state_q == IDLE);

    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;
        ram_wr_en_d  = 1'b0;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = resp_rdata_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (!is_aligned(req_size, req_addr[1:0])) begin
                        // Rejected without touching the RAM.
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = 32'h0;
                    end else begin
                        ram_addr_d = {req_addr[ADDR_W-1:2], 2'b00};
                        req_d      = '{size: req_size, off: req_addr[1:0],
                                       sgn: req_signed, wdata: req_wdata};
                        if (!req_we) begin
                            state_d = LD_ADDR;
                        end else if (req_size == SIZE_W) begin
                            ram_wdata_d = req_wdata;
                            ram_wr_en_d = 1'b1;
                            state_d     = ST_WRITE;
                        end else begin
                            state_d = RMW_ADDR;
                        end
                    end
                end
            end
            LD_ADDR:  state_d = LD_DATA;
            LD_DATA: begin
                resp_rdata_d = ld_word;
                resp_valid_d = 1'b1;
                state_d      = IDLE;
            end
            ST_WRITE: begin
                resp_valid_d = 1'b1;
                resp_rdata_d = 32'h0;
                state_d      = IDLE;
            end
            RMW_ADDR: state_d = RMW_DATA;
            RMW_DATA: begin
                // Old word is on ram_data now; untouched lanes keep it.
                ram_wdata_d = rmw_word;
                ram_wr_en_d = 1'b1;
                state_d     = RMW_WRITE;
            end
            RMW_WRITE: begin
                resp_valid_d = 1'b1;
                resp_rdata_d = 32'h0;
                state_d      = IDLE;
            end
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            req_q        <= '0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= 32'h0;
            ram_wr_en_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'h0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            ram_wr_en_q  <= ram_wr_en_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    assign ram_wr_en      = ram_wr_en_q;
    assign ram_address    = ram_addr_q;
    assign ram_write_data = ram_wdata_q;
    assign resp_valid     = resp_valid_q;
    assign resp_err       = resp_err_q;
    assign resp_rdata     = resp_rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboarded bench for mem_access_unit with a synchronous-read RAM model.
module tb_mem_access_unit;

    localparam int ADDR_W = 20;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid, req_ready, req_we, req_signed;
    logic [1:0]        req_size;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid, resp_err;
    logic [31:0]       resp_rdata;
    logic              ram_wr_en;
    logic [ADDR_W-1:0] ram_address;
    logic [31:0]       ram_write_data, ram_data;

    mem_access_unit #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
        .ram_wr_en(ram_wr_en), .ram_address(ram_address),
        .ram_write_data(ram_write_data), .ram_data(ram_data)
    );

    always #5 clk = ~clk;

    // RAM model: word write at edge, registered read address.
    logic [31:0] mem [0:(1<<18)-1];
    logic [31:0] ram_q;
    logic        pre_we = 1'b0;
    logic [17:0] pre_idx = '0;
    logic [31:0] pre_val = '0;
    always @(posedge clk) begin
        if (ram_wr_en)   mem[ram_address[19:2]] <= ram_write_data;
        else if (pre_we) mem[pre_idx] <= pre_val;
        ram_q <= mem[ram_address[19:2]];
    end
    assign ram_data = ram_q;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          acc;
    } exp_t;
    exp_t exp_q[$];

    int tests = 0, fails = 0;
    int wr_cnt = 0, last_resp = 0, prev_resp = 0;
    logic [ADDR_W-1:0] last_wr_addr = '0;
    logic prev_wr = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor / scoreboard
    exp_t e;
    always @(negedge clk) begin
        if (!rst) begin
            if (resp_valid) begin
                if (exp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_resp: got err=%b rdata=%h expected none", resp_err, resp_rdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("resp_err", {31'b0, resp_err}, {31'b0, e.err});
                    chk("resp_rdata", resp_rdata, e.rdata);
                    chk("resp_latency", cyc - e.acc, e.lat);
                    prev_resp = last_resp;
                    last_resp = cyc;
                end
            end
            if (ram_wr_en) begin
                wr_cnt++;
                last_wr_addr = ram_address;
                chk("wr_en_single_cycle", {31'b0, prev_wr}, 32'h0);
                chk("wr_addr_aligned", {30'b0, ram_address[1:0]}, 32'h0);
            end
            prev_wr = ram_wr_en;
        end else begin
            prev_wr = 1'b0;
        end
    end

    task automatic poke(input logic [19:0] a, input logic [31:0] v);
        @(negedge clk);
        pre_we = 1'b1; pre_idx = a[19:2]; pre_val = v;
        @(posedge clk); #1;
        pre_we = 1'b0;
    endtask

    // lat = cycles from the request-presented cycle to the resp_valid cycle
    task automatic issue(input logic we, input logic [1:0] sz, input logic sg,
                         input logic [19:0] a, input logic [31:0] wd,
                         input logic xerr, input logic [31:0] xrd, input int lat);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        if (!req_ready) begin
            tests++; fails++;
            $display("FAIL req_ready_timeout: got 0 expected 1");
            return;
        end
        req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = wd;
        exp_q.push_back('{xerr, xrd, lat, cyc});
        @(posedge clk); #1;
        // Scramble fields after accept; the unit must have latched them.
        req_valid = 1'b0; req_addr = ~a; req_wdata = ~wd; req_signed = ~sg;
        req_size = ~sz;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || !req_ready) && n < 40) begin @(negedge clk); n++; end
        if (exp_q.size() != 0 || !req_ready) begin
            tests++; fails++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
        @(negedge clk);
    endtask

    int wr_before;

    initial begin
        rst = 1'b1; req_valid = 0; req_we = 0; req_size = 0; req_signed = 0;
        req_addr = '0; req_wdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", {31'b0, req_ready}, 32'h1);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
        chk("rst_resp_err", {31'b0, resp_err}, 32'h0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_wr_en", {31'b0, ram_wr_en}, 32'h0);
        chk("rst_ram_address", {12'b0, ram_address}, 32'h0);
        chk("rst_ram_wdata", ram_write_data, 32'h0);
        rst = 1'b0;

        poke(20'h20, 32'h1122_3344);
        poke(20'h28, 32'hCAFE_F00D);
        poke(20'h30, 32'h80FF_7F01);

        // Word store then load
        issue(1, 2'd2, 0, 20'h10, 32'hDEAD_BEEF, 0, 32'h0, 2);
        drain();
        chk("st_wr_addr", {12'b0, last_wr_addr}, 32'h10);
        issue(0, 2'd2, 0, 20'h10, 32'h0, 0, 32'hDEAD_BEEF, 3);
        drain();

        // Sub-word RMW stores (junk in unused wdata bits)
        issue(1, 2'd0, 0, 20'h22, 32'h1234_56AA, 0, 32'h0, 4);
        drain();
        chk("rmw_byte_mem", mem[18'h20 >> 2], 32'h11AA_3344);
        issue(1, 2'd1, 0, 20'h2A, 32'hFFFF_1234, 0, 32'h0, 4);
        drain();
        chk("rmw_half_mem", mem[18'h28 >> 2], 32'h1234_F00D);
        issue(1, 2'd0, 0, 20'h2B, 32'h0000_005A, 0, 32'h0, 4);
        drain();
        chk("rmw_byte3_mem", mem[18'h28 >> 2], 32'h5A34_F00D);

        // Sign/zero extension
        issue(0, 2'd0, 1, 20'h32, 32'h0, 0, 32'hFFFF_FFFF, 3);
        issue(0, 2'd0, 0, 20'h32, 32'h0, 0, 32'h0000_00FF, 3);
        issue(0, 2'd1, 1, 20'h32, 32'h0, 0, 32'hFFFF_80FF, 3);
        issue(0, 2'd0, 1, 20'h31, 32'h0, 0, 32'h0000_007F, 3);
        issue(0, 2'd1, 0, 20'h30, 32'h0, 0, 32'h0000_7F01, 3);
        issue(0, 2'd0, 1, 20'h33, 32'h0, 0, 32'hFFFF_FF80, 3);
        drain();

        // Misaligned / illegal
        issue(0, 2'd1, 0, 20'h31, 32'h0, 1, 32'h0, 1);
        issue(1, 2'd2, 0, 20'h22, 32'hFFFF_FFFF, 1, 32'h0, 1);
        issue(0, 2'd3, 0, 20'h30, 32'h0, 1, 32'h0, 1);
        drain();
        chk("misaligned_mem", mem[18'h20 >> 2], 32'h11AA_3344);

        // Back-to-back loads
        issue(0, 2'd2, 0, 20'h10, 32'h0, 0, 32'hDEAD_BEEF, 3);
        issue(0, 2'd2, 0, 20'h30, 32'h0, 0, 32'h80FF_7F01, 3);
        drain();
        chk("b2b_spacing", last_resp - prev_resp, 32'd3);
        chk("wr_en_count", wr_cnt, 32'd4);

        // Reset during RMW_DATA
        poke(20'h40, 32'h5566_7788);
        wr_before = wr_cnt;
        @(negedge clk);
        req_valid = 1; req_we = 1; req_size = 2'd0; req_signed = 0;
        req_addr = 20'h41; req_wdata = 32'h99;
        @(posedge clk); #1 req_valid = 0;
        @(posedge clk); #2 rst = 1'b1;
        #1;
        chk("rst_mid_wr_en", {31'b0, ram_wr_en}, 32'h0);
        chk("rst_mid_resp_valid", {31'b0, resp_valid}, 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("rst_mid_ready", {31'b0, req_ready}, 32'h1);
        chk("rst_mid_mem", mem[18'h40 >> 2], 32'h5566_7788);
        chk("rst_mid_wr_count", wr_cnt, wr_before);
        chk("rst_mid_ram_address", {12'b0, ram_address}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
